reg16_byte_reader: RTL

- Read-side companion to the 16-bit loadable registers in SC8bCPU.
- Snapshots a 16-bit register value on request and delivers it over the CPU's 8-bit data bus as two bytes.
- Each byte uses a VALID/READY handshake.
- Used wherever a 16-bit register (PC, address, stack pointer) must be read byte-wise by the 8-bit datapath or an external bus master.

---
 rtl/reg16_byte_reader_pkg.sv | 22 ++
 rtl/reg_16_bit.sv | 27 ++
 rtl/reg16_byte_reader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/reg16_byte_reader_pkg.sv
// Shared definitions for the 16-bit register byte reader: widths, FSM encoding, byte pick helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reg16_byte_reader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    // 2'b11 is unused; the FSM treats it as illegal and returns to IDLE
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FIRST  = 2'b01,
        ST_SECOND = 2'b10
    } state_e;

    // Select the high (1) or low (0) byte of a word
    function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] word,
                                                    input logic              high);
        return high ? word[WORD_W-1:BYTE_W] : word[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/reg_16_bit.sv
// 16-bit loadable register with asynchronous active-low clear.
// Latency: value appears on out_o one cycle after load_i.
// Backpressure: none; loads whenever load_i is high.
module reg_16_bit
    import reg16_byte_reader_pkg::*;
(
    input  logic              clk_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] in_i,
    output logic [WORD_W-1:0] out_o
);

    logic [WORD_W-1:0] val_q;

    // Hold the word; clear to zero immediately while clear_i is low
    always_ff @(posedge clk_i or negedge clear_i) begin
        if (!clear_i) begin
            val_q <= '0;
        end else if (load_i) begin
            val_q <= in_i;
        end
    end

    assign out_o = val_q;

endmodule

// File: rtl/reg16_byte_reader.sv
// Snapshots a 16-bit value on start and streams it as two bytes over a valid/ready bus.
// Latency: first byte valid the cycle after the start edge; minimum transfer is 2 accepted edges + DONE pulse.
// Backpressure: bus_out_o/bus_valid_o hold stable while bus_ready_i is low; start is ignored while busy.
module reg16_byte_reader
    import reg16_byte_reader_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [WORD_W-1:0] in_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic [BYTE_W-1:0] bus_out_o,
    output logic              bus_valid_o,
    input  logic              bus_ready_i,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] hold_q;
    logic              hold_load;
    logic              hold_clr_n;
    logic              handshake;

    logic [BYTE_W-1:0] bus_out_q, bus_out_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    assign handshake  = valid_q & bus_ready_i;
    assign hold_load  = start_i & (state_q == ST_IDLE) & ~abort_i;
    assign hold_clr_n = ~rst_i;

    reg_16_bit u_hold (
        .clk_i   (clk_i),
        .clear_i (hold_clr_n),
        .load_i  (hold_load),
        .in_i    (in_i),
        .out_o   (hold_q)
    );

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: abort wins over a handshake in either byte phase
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) state_d = ST_FIRST;
            end
            ST_FIRST: begin
                if (abort_i)        state_d = ST_IDLE;
                else if (handshake) state_d = ST_SECOND;
            end
            ST_SECOND: begin
                if (abort_i || handshake) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values derived from the state being entered
    always_comb begin
        bus_out_d = '0;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        busy_d    = 1'b0;
        case (state_d)
            ST_FIRST: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                // The hold register loads on this same edge, so the first
                // byte is taken straight from in_i on entry and then held.
                bus_out_d = (state_q == ST_IDLE) ? pick_byte(in_i, HIGH_FIRST)
                                                 : bus_out_q;
            end
            ST_SECOND: begin
                valid_d   = 1'b1;
                busy_d    = 1'b1;
                last_d    = 1'b1;
                bus_out_d = pick_byte(hold_q, ~HIGH_FIRST);
            end
            default: ;
        endcase
        done_d = (state_q == ST_SECOND) & handshake & ~abort_i;
    end

    // Registered outputs so no input reaches an output combinationally
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus_out_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            bus_out_q <= bus_out_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus_out_o   = bus_out_q;
    assign bus_valid_o = valid_q;
    assign last_o      = last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
